// File: rtl/axi4full_sram_burst.sv
// axi4full_sram_burst
//   AXI4-full slave in front of an internal synchronous SRAM of DEPTH words,
//   each DATA_WIDTH bits wide. It supports FIXED, INCR and WRAP bursts on both
//   channels, byte strobes, ID echo and beat-accurate back-pressure. The read
//   and write channels run as independent state machines.
//
//   Optional feature: define YSYX_22050710_SRAM_RANGE_CHECK_EN to flag beats
//   whose byte address is >= DEPTH*STRB_WIDTH.
//     - Such a read beat returns zero data with SLVERR.
//     - Such a write beat is dropped and makes the burst end with SLVERR.
//   Without the macro, the word index wraps modulo DEPTH.
//
// Ports
//   i_aclk, i_areset             clock, synchronous active-high reset
//   i_aw*/o_awready              write address channel
//   i_w*/o_wready                write data channel (data, strobes, last)
//   o_b*/i_bready                write response channel
//   i_ar*/o_arready              read address channel
//   o_r*/i_rready                read data channel (data, id, resp, last)
module axi4full_sram_burst #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  // write address
  input  logic [ID_WIDTH-1:0]   i_awid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic [2:0]            i_awsize,
  input  logic [1:0]            i_awburst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  // write data
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  // write response
  output logic [ID_WIDTH-1:0]   o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  // read address
  input  logic [ID_WIDTH-1:0]   i_arid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  // read data
  output logic [ID_WIDTH-1:0]   o_rid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready
);

  localparam int unsigned LSB  = $clog2(STRB_WIDTH);
  localparam int unsigned IDXW = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Address of the beat that follows addr; the reserved burst type 11 behaves as INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [7:0]            len,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    step = ADDR_WIDTH'(1) << size;
    inc  = addr + step;
    mask = (step * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1))) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (inc & mask);
      default:     next_addr = inc;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [7:0]            r_cnt;

  logic [ADDR_WIDTH-1:0] r_fetch_c;
  logic                  r_oor_c;
  logic [DATA_WIDTH-1:0] r_word_c;
  logic [1:0]            r_resp_c;

  // Address of the beat to be fetched on this edge: the burst start in idle,
  // otherwise the beat following the one currently presented.
  always_comb begin
    r_fetch_c = next_addr(r_addr, r_size, r_len, r_burst);
    if (r_state == R_IDLE) begin
      r_fetch_c = i_araddr;
    end
  end

`ifdef YSYX_22050710_SRAM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH * STRB_WIDTH);
  assign r_oor_c = ({1'b0, r_fetch_c} >= MEM_BYTES);
`else
  assign r_oor_c = 1'b0;
`endif

  // Array read for the next presented beat; old data wins on a same-edge write.
  always_comb begin
    r_word_c = mem[r_fetch_c[LSB +: IDXW]];
    r_resp_c = RESP_OKAY;
    if (r_oor_c) begin
      r_word_c = '0;
      r_resp_c = RESP_SLVERR;
    end
  end

  // Read FSM: one beat is loaded on accept and on every non-last handshake.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state   <= R_IDLE;
      o_arready <= 1'b0;
      o_rvalid  <= 1'b0;
      o_rlast   <= 1'b0;
      o_rdata   <= '0;
      o_rid     <= '0;
      o_rresp   <= RESP_OKAY;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          o_arready <= 1'b1;
          if (o_arready && i_arvalid) begin
            o_arready <= 1'b0;
            o_rvalid  <= 1'b1;
            o_rlast   <= (i_arlen == 8'd0);
            o_rid     <= i_arid;
            o_rdata   <= r_word_c;
            o_rresp   <= r_resp_c;
            r_addr    <= r_fetch_c;
            r_len     <= i_arlen;
            r_size    <= i_arsize;
            r_burst   <= i_arburst;
            r_cnt     <= 8'd0;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (i_rready) begin
            if (o_rlast) begin
              o_rvalid  <= 1'b0;
              o_rlast   <= 1'b0;
              o_arready <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              o_rlast <= ((r_cnt + 8'd1) == r_len);
              o_rdata <= r_word_c;
              o_rresp <= r_resp_c;
              r_addr  <= r_fetch_c;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [7:0]            w_cnt;
  logic                  w_err;

  logic                  w_fire_c;
  logic                  w_last_beat_c;
  logic                  w_oor_c;
  logic                  w_err_c;
  logic                  w_we_c;

`ifdef YSYX_22050710_SRAM_RANGE_CHECK_EN
  assign w_oor_c = ({1'b0, w_addr} >= MEM_BYTES);
`else
  assign w_oor_c = 1'b0;
`endif

  // Beat bookkeeping: a wlast that disagrees with the beat count is a sticky error.
  always_comb begin
    w_fire_c      = o_wready & i_wvalid;
    w_last_beat_c = (w_cnt == w_len);
    w_err_c       = w_err | (i_wlast != w_last_beat_c) | w_oor_c;
    w_we_c        = w_fire_c & ~i_areset & ~w_oor_c;
  end

  // Strobed array write; kept outside the reset domain so contents survive reset.
  always_ff @(posedge i_aclk) begin
    if (w_we_c) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (i_wstrb[b]) begin
          mem[w_addr[LSB +: IDXW]][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Write FSM: accept address, take len+1 beats, then hold the response.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      w_state   <= W_IDLE;
      o_awready <= 1'b0;
      o_wready  <= 1'b0;
      o_bvalid  <= 1'b0;
      o_bid     <= '0;
      o_bresp   <= RESP_OKAY;
      w_addr    <= '0;
      w_len     <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_cnt     <= '0;
      w_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          o_awready <= 1'b1;
          if (o_awready && i_awvalid) begin
            o_awready <= 1'b0;
            o_wready  <= 1'b1;
            o_bid     <= i_awid;
            w_addr    <= i_awaddr;
            w_len     <= i_awlen;
            w_size    <= i_awsize;
            w_burst   <= i_awburst;
            w_cnt     <= 8'd0;
            w_err     <= 1'b0;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire_c) begin
            w_err <= w_err_c;
            if (w_last_beat_c) begin
              o_wready <= 1'b0;
              o_bvalid <= 1'b1;
              o_bresp  <= w_err_c ? RESP_SLVERR : RESP_OKAY;
              w_state  <= W_RESP;
            end else begin
              w_cnt  <= w_cnt + 8'd1;
              w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
            end
          end
        end
        W_RESP: begin
          if (i_bready) begin
            o_bvalid  <= 1'b0;
            o_awready <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4full_sram_burst.sv
// Self-checking bench for axi4full_sram_burst: directed scenarios followed by
// randomized bursts, all checked against a byte-level memory model.
module tb_axi4full_sram_burst;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = 4;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned SW    = DW / 8;

  logic          i_aclk = 1'b0;
  logic          i_areset = 1'b1;
  logic [IW-1:0] i_awid = '0;
  logic [AW-1:0] i_awaddr = '0;
  logic [7:0]    i_awlen = '0;
  logic [2:0]    i_awsize = '0;
  logic [1:0]    i_awburst = '0;
  logic          i_awvalid = 1'b0;
  logic          o_awready;
  logic [DW-1:0] i_wdata = '0;
  logic [SW-1:0] i_wstrb = '0;
  logic          i_wlast = 1'b0;
  logic          i_wvalid = 1'b0;
  logic          o_wready;
  logic [IW-1:0] o_bid;
  logic [1:0]    o_bresp;
  logic          o_bvalid;
  logic          i_bready = 1'b0;
  logic [IW-1:0] i_arid = '0;
  logic [AW-1:0] i_araddr = '0;
  logic [7:0]    i_arlen = '0;
  logic [2:0]    i_arsize = '0;
  logic [1:0]    i_arburst = '0;
  logic          i_arvalid = 1'b0;
  logic          o_arready;
  logic [IW-1:0] o_rid;
  logic [DW-1:0] o_rdata;
  logic [1:0]    o_rresp;
  logic          o_rlast;
  logic          o_rvalid;
  logic          i_rready = 1'b0;

  always #5 i_aclk = ~i_aclk;

  axi4full_sram_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DEPTH(DEPTH), .STRB_WIDTH(SW)
  ) dut (
    .i_aclk(i_aclk), .i_areset(i_areset),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
    .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
    .o_rvalid(o_rvalid), .i_rready(i_rready)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] mdl [DEPTH];
  logic [63:0] wb_data [256];
  logic [7:0]  wb_strb [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte address of beat i, derived from the burst rules with plain arithmetic.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size,
                                            input int len, input int burst, input int i);
    int unsigned step;
    int unsigned total;
    logic [31:0] base;
    step  = 1 << size;
    total = step * (len + 1);
    case (burst)
      0: return start;
      2: begin
        base = start & ~(total - 1);
        return base + ((start - base + i * step) % total);
      end
      default: return start + i * step;
    endcase
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 3) % DEPTH;
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int bad_beat,
                           input logic [1:0] exp_bresp);
    int k;
    int unsigned ix;
    @(negedge i_aclk);
    i_awid = id; i_awaddr = addr; i_awlen = 8'(len); i_awsize = 3'(size);
    i_awburst = 2'(burst); i_awvalid = 1'b1;
    k = 0;
    while (!o_awready && k < 50) begin @(negedge i_aclk); k++; end
    chk("aw_timeout", 64'(k >= 50), 64'd0);
    @(negedge i_aclk);
    i_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      i_wdata = wb_data[i]; i_wstrb = wb_strb[i];
      i_wlast = (i == len) ^ (i == bad_beat);
      i_wvalid = 1'b1;
      k = 0;
      while (!o_wready && k < 50) begin @(negedge i_aclk); k++; end
      chk("w_timeout", 64'(k >= 50), 64'd0);
      @(negedge i_aclk);
    end
    i_wvalid = 1'b0; i_wlast = 1'b0;
    for (int i = 0; i <= len; i++) begin
      ix = widx(beat_addr(addr, size, len, burst, i));
      for (int b = 0; b < 8; b++)
        if (wb_strb[i][b]) mdl[ix][b*8 +: 8] = wb_data[i][b*8 +: 8];
    end
    chk("bvalid_next_cycle", 64'(o_bvalid), 64'd1);
    k = $urandom_range(0, 2);
    for (int d = 0; d < k; d++) begin
      @(negedge i_aclk);
      chk("bvalid_hold", 64'(o_bvalid), 64'd1);
    end
    i_bready = 1'b1;
    chk("bid", 64'(o_bid), 64'(id));
    chk("bresp", 64'(o_bresp), 64'(exp_bresp));
    @(negedge i_aclk);
    i_bready = 1'b0;
    chk("bvalid_clear", 64'(o_bvalid), 64'd0);
    chk("awready_after_b", 64'(o_awready), 64'd1);
  endtask

  // rr_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int rr_mode);
    int k;
    int beat;
    int cyc;
    logic rr;
    logic stalled;
    logic [63:0] prev_data;
    logic prev_last;
    logic [3:0] pat;
    pat = 4'b1001;
    @(negedge i_aclk);
    i_arid = id; i_araddr = addr; i_arlen = 8'(len); i_arsize = 3'(size);
    i_arburst = 2'(burst); i_arvalid = 1'b1;
    k = 0;
    while (!o_arready && k < 50) begin @(negedge i_aclk); k++; end
    chk("ar_timeout", 64'(k >= 50), 64'd0);
    @(negedge i_aclk);
    i_arvalid = 1'b0;
    beat = 0; cyc = 0; stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (beat <= len && cyc < 2000) begin
      case (rr_mode)
        0:       rr = 1'b1;
        1:       rr = pat[cyc % 4];
        default: rr = 1'($urandom_range(0, 1));
      endcase
      i_rready = rr;
      chk("rvalid_in_burst", 64'(o_rvalid), 64'd1);
      chk("arready_in_burst", 64'(o_arready), 64'd0);
      if (stalled) begin
        chk("rdata_stable", o_rdata, prev_data);
        chk("rlast_stable", 64'(o_rlast), 64'(prev_last));
      end
      if (rr) begin
        chk("rdata", o_rdata, mdl[widx(beat_addr(addr, size, len, burst, beat))]);
        chk("rlast", 64'(o_rlast), 64'(beat == len));
        chk("rid", 64'(o_rid), 64'(id));
        chk("rresp", 64'(o_rresp), 64'd0);
        beat++;
      end
      stalled = !rr; prev_data = o_rdata; prev_last = o_rlast;
      @(negedge i_aclk);
      cyc++;
    end
    i_rready = 1'b0;
    chk("r_timeout", 64'(cyc >= 2000), 64'd0);
    chk("rvalid_after_last", 64'(o_rvalid), 64'd0);
    chk("arready_after_last", 64'(o_arready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned burst, size, len;
    logic [31:0] addr;
    logic [3:0]  id;
    int k;

    // Reset state
    repeat (3) @(negedge i_aclk);
    chk("rst_rvalid", 64'(o_rvalid), 64'd0);
    chk("rst_bvalid", 64'(o_bvalid), 64'd0);
    chk("rst_arready", 64'(o_arready), 64'd0);
    chk("rst_awready", 64'(o_awready), 64'd0);
    chk("rst_wready", 64'(o_wready), 64'd0);
    chk("rst_rlast", 64'(o_rlast), 64'd0);
    chk("rst_rdata", o_rdata, 64'd0);
    chk("rst_bresp", 64'(o_bresp), 64'd0);
    i_areset = 1'b0;
    @(negedge i_aclk);
    chk("arready_post_rst", 64'(o_arready), 64'd1);
    chk("awready_post_rst", 64'(o_awready), 64'd1);

    // Fill words 0..255 with a 256-beat INCR burst and read it all back
    for (int i = 0; i < 256; i++) begin
      wb_data[i] = {$urandom, $urandom}; wb_strb[i] = 8'hFF;
    end
    axi_write(4'h1, 32'h0, 255, 3, 1, -1, 2'b00);
    axi_read(4'h2, 32'h0, 255, 3, 1, 0);

    // INCR write/read at 0x100
    wb_data[0] = 64'h11; wb_data[1] = 64'h22; wb_data[2] = 64'h33; wb_data[3] = 64'h44;
    for (int i = 0; i < 4; i++) wb_strb[i] = 8'hFF;
    axi_write(4'h5, 32'h100, 3, 3, 1, -1, 2'b00);
    axi_read(4'h5, 32'h100, 3, 3, 1, 0);

    // WRAP read from 0x118: beats 0x118, 0x100, 0x108, 0x110
    axi_read(4'h6, 32'h118, 3, 3, 2, 0);
    chk("wrap_model_beat1", mdl[widx(beat_addr(32'h118, 3, 3, 2, 1))], 64'h11);

    // FIXED write with merging strobes
    wb_data[0] = 64'hA1A2A3A4A5A6A7A8; wb_strb[0] = 8'h0F;
    wb_data[1] = 64'hB1B2B3B4B5B6B7B8; wb_strb[1] = 8'hF0;
    wb_data[2] = 64'hC1C2C3C4C5C6C7C8; wb_strb[2] = 8'h01;
    axi_write(4'h7, 32'h200, 2, 3, 0, -1, 2'b00);
    axi_read(4'h7, 32'h200, 0, 3, 1, 0);
    chk("fixed_merge_word", mdl[64], 64'hB1B2B3B4A5A6A7C8);

    // Back-pressured read with rready 1,0,0,1
    axi_read(4'h8, 32'h100, 3, 3, 1, 1);

    // Early wlast: both beats still written, SLVERR
    wb_data[0] = 64'hDEAD0001; wb_data[1] = 64'hDEAD0002;
    wb_strb[0] = 8'hFF; wb_strb[1] = 8'hFF;
    axi_write(4'h9, 32'h300, 1, 3, 1, 0, 2'b10);
    axi_read(4'h9, 32'h300, 1, 3, 1, 0);

    // Reset on beat 2 of an 8-beat read
    @(negedge i_aclk);
    i_arid = 4'hA; i_araddr = 32'h0; i_arlen = 8'd7; i_arsize = 3'd3;
    i_arburst = 2'b01; i_arvalid = 1'b1;
    k = 0;
    while (!o_arready && k < 50) begin @(negedge i_aclk); k++; end
    chk("rst_ar_timeout", 64'(k >= 50), 64'd0);
    @(negedge i_aclk);
    i_arvalid = 1'b0; i_rready = 1'b1;
    @(negedge i_aclk);
    @(negedge i_aclk);
    chk("rst_beat2_data", o_rdata, mdl[2]);
    chk("rst_beat2_valid", 64'(o_rvalid), 64'd1);
    i_rready = 1'b0; i_areset = 1'b1;
    @(negedge i_aclk);
    chk("midrst_rvalid", 64'(o_rvalid), 64'd0);
    chk("midrst_arready", 64'(o_arready), 64'd0);
    chk("midrst_rlast", 64'(o_rlast), 64'd0);
    chk("midrst_rdata", o_rdata, 64'd0);
    chk("midrst_rid", 64'(o_rid), 64'd0);
    chk("midrst_bid", 64'(o_bid), 64'd0);
    i_areset = 1'b0;
    @(negedge i_aclk);
    chk("postrst_arready", 64'(o_arready), 64'd1);
    chk("postrst_rvalid", 64'(o_rvalid), 64'd0);
    // Array contents survive reset
    axi_read(4'hB, 32'h100, 3, 3, 1, 0);

`ifdef YSYX_22050710_SRAM_RANGE_CHECK_EN
    @(negedge i_aclk);
    i_arid = 4'hC; i_araddr = 32'(DEPTH * 8); i_arlen = 8'd0; i_arsize = 3'd3;
    i_arburst = 2'b01; i_arvalid = 1'b1;
    k = 0;
    while (!o_arready && k < 50) begin @(negedge i_aclk); k++; end
    @(negedge i_aclk);
    i_arvalid = 1'b0;
    chk("oor_rdata", o_rdata, 64'd0);
    chk("oor_rresp", 64'(o_rresp), 64'd2);
    i_rready = 1'b1;
    @(negedge i_aclk);
    i_rready = 1'b0;
`endif

    // Randomized bursts
    for (int t = 0; t < 30; t++) begin
      burst = $urandom_range(0, 3);
      size  = $urandom_range(0, 3);
      if (burst == 2) len = (2 << $urandom_range(0, 3)) - 1;
      else            len = $urandom_range(0, 15);
      addr = 32'($urandom_range(0, 63)) << size;
      id   = 4'($urandom_range(0, 15));
      for (int i = 0; i <= int'(len); i++) begin
        wb_data[i] = {$urandom, $urandom}; wb_strb[i] = 8'($urandom);
      end
      axi_write(id, addr, int'(len), int'(size), int'(burst), -1, 2'b00);
      axi_read(~id, addr, int'(len), int'(size), int'(burst), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
